// File: rtl/inv_key_sched.sv
// Inverse AES-128 key schedule: walks round keys from round NUM_ROUNDS back to 0, one per handshake.
// Optional macro ROUND_KEY_CACHE_EN adds a round-key cache that can be re-streamed with replay.
module inv_key_sched #(
    parameter int          NUM_ROUNDS = 10,
    parameter logic [7:0]  LAST_RCON  = 8'h36
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         replay,
    input  logic         key_ready,
    output logic         key_valid,
    output logic [127:0] key_out,
    output logic [3:0]   key_round,
    output logic         busy,
    output logic         done
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT,
        S_DONE
`ifdef ROUND_KEY_CACHE_EN
        , S_REPLAY
`endif
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    function automatic logic [7:0] inv_xtime(input logic [7:0] r);
        return r[0] ? (((r ^ 8'h1b) >> 1) | 8'h80) : (r >> 1);
    endfunction

    state_t       r_state, w_next;
    logic [127:0] r_key;
    logic [3:0]   r_round;
    logic [7:0]   r_rcon;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3, w_p0, w_p1, w_p2, w_p3, w_rot, w_sub;
    logic [127:0] w_prev;
    logic         w_accept_last;

    assign {w_w0, w_w1, w_w2, w_w3} = r_key;
    assign w_p3   = w_w3 ^ w_w2;
    assign w_p2   = w_w2 ^ w_w1;
    assign w_p1   = w_w1 ^ w_w0;
    assign w_rot  = {w_p3[23:0], w_p3[31:24]};
    assign w_sub  = {SBOX[w_rot[31:24]], SBOX[w_rot[23:16]], SBOX[w_rot[15:8]], SBOX[w_rot[7:0]]};
    assign w_p0   = w_w0 ^ w_sub ^ {r_rcon, 24'h0};
    assign w_prev = {w_p0, w_p1, w_p2, w_p3};
    assign w_accept_last = key_ready && (r_round == 4'd0);

`ifdef ROUND_KEY_CACHE_EN
    logic [127:0] r_cache [0:NUM_ROUNDS];
    logic         r_cache_vld;

    // Cache array needs no reset; r_cache_vld guards every read.
    always_ff @(posedge clk) begin
        if (r_state == S_EMIT && key_ready)
            r_cache[r_round] <= r_key;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            r_cache_vld <= 1'b0;
        else if (r_state == S_IDLE && start)
            r_cache_vld <= 1'b0;
        else if (r_state == S_EMIT && w_accept_last)
            r_cache_vld <= 1'b1;
    end
`else
    logic w_unused_replay;
    assign w_unused_replay = replay;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_EMIT;
`ifdef ROUND_KEY_CACHE_EN
                else if (replay && r_cache_vld) w_next = S_REPLAY;
`endif
            end
            S_EMIT:   if (w_accept_last) w_next = S_DONE;
`ifdef ROUND_KEY_CACHE_EN
            S_REPLAY: if (w_accept_last) w_next = S_DONE;
`endif
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_key   <= '0;
            r_round <= '0;
            r_rcon  <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_key   <= key_in;
            r_round <= 4'(NUM_ROUNDS);
            r_rcon  <= LAST_RCON;
        end else if (r_state == S_EMIT && key_ready && r_round != 4'd0) begin
            r_key   <= w_prev;
            r_round <= r_round - 4'd1;
            r_rcon  <= inv_xtime(r_rcon);
        end
`ifdef ROUND_KEY_CACHE_EN
        else if (r_state == S_IDLE && replay && r_cache_vld)
            r_round <= 4'(NUM_ROUNDS);
        else if (r_state == S_REPLAY && key_ready && r_round != 4'd0)
            r_round <= r_round - 4'd1;
`endif
    end

    always_comb begin
        key_valid = 1'b0;
        key_out   = '0;
        key_round = '0;
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE);
        case (r_state)
            S_EMIT: begin
                key_valid = 1'b1;
                key_out   = r_key;
                key_round = r_round;
            end
`ifdef ROUND_KEY_CACHE_EN
            S_REPLAY: begin
                key_valid = 1'b1;
                key_out   = r_cache[r_round];
                key_round = r_round;
            end
`endif
            default: ;
        endcase
    end
endmodule

// File: tb/tb_inv_key_sched.sv
// Self-checking bench for inv_key_sched using the FIPS-197 A.1 key expansion as reference.
module tb_inv_key_sched;
    logic         clk = 1'b0, n_rst = 1'b0, start = 1'b0, replay = 1'b0, key_ready = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_valid, busy, done;
    logic [127:0] key_out;
    logic [3:0]   key_round;

    inv_key_sched dut (
        .clk(clk), .n_rst(n_rst), .start(start), .key_in(key_in), .replay(replay),
        .key_ready(key_ready), .key_valid(key_valid), .key_out(key_out),
        .key_round(key_round), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [127:0] key; logic [3:0] rnd; } exp_t;
    exp_t         sb[$];
    logic [127:0] fips [0:10];
    logic [7:0]   rc_tab [0:9];
    int           n_checks = 0, n_fail = 0;

    task automatic load_walk(input logic [127:0] dummy);
        sb.delete();
        for (int r = 10; r >= 0; r--) sb.push_back({fips[r], 4'(r)});
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({key_valid, busy, done, key_round} !== 7'd0 || key_out !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_state got v=%b b=%b d=%b r=%0d k=%h want all 0", key_valid, busy, done, key_round, key_out);
        end
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    // Full walk with key_ready high; key_in scrambled after the accepting cycle.
    task automatic test_fips(input string name, input int start_at, input int stall_n);
        exp_t e; int cyc = 0, acc = 0, stall = 0;
        key_in = fips[10]; start = 1'b1; key_ready = 1'b1;
        load_walk('0);
        while (sb.size() > 0 && cyc < 60) begin
            @(negedge clk);
            start = 1'b0; key_in = ~fips[10]; cyc++;
            if (cyc == start_at) begin start = 1'b1; key_in = fips[0]; end
            if (done) begin
                n_checks++; n_fail++;
                $display("FAIL %s early_done at cycle %0d", name, cyc);
            end
            key_ready = 1'b1;
            if (key_valid && key_round == 4'd9 && stall < stall_n) begin
                key_ready = 1'b0; stall++; n_checks++;
                if (key_out !== sb[0].key || key_round !== 4'd9) begin
                    n_fail++;
                    $display("FAIL %s hold got %h/%0d want %h/9", name, key_out, key_round, sb[0].key);
                end
            end
            if (key_valid && key_ready) begin
                if (key_round >= 4'd1 && key_round <= 4'd10) begin
                    n_checks++;
                    if (dut.r_rcon !== rc_tab[10 - key_round]) begin
                        n_fail++;
                        $display("FAIL %s rcon r%0d got %h want %h", name, key_round, dut.r_rcon, rc_tab[10 - key_round]);
                    end
                end
                e = sb.pop_front(); acc++; n_checks++;
                if (key_out !== e.key || key_round !== e.rnd) begin
                    n_fail++;
                    $display("FAIL %s key got %h/%0d want %h/%0d", name, key_out, key_round, e.key, e.rnd);
                end
            end
        end
        start = 1'b0;
        n_checks++;
        if (sb.size() != 0 || acc != 11 || stall != stall_n) begin
            n_fail++;
            $display("FAIL %s count got acc=%0d stall=%0d want acc=11 stall=%0d", name, acc, stall, stall_n);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_pulse got d=%b v=%b want d=1 v=0", name, done, key_valid);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle got d=%b b=%b want 0 0", name, done, busy);
        end
    endtask

    task automatic test_replay();
`ifdef ROUND_KEY_CACHE_EN
        exp_t e; int cyc = 0, acc = 0;
        replay = 1'b1; key_ready = 1'b1;
        load_walk('0);
        while (sb.size() > 0 && cyc < 40) begin
            @(negedge clk);
            replay = 1'b0; cyc++;
            if (key_valid && key_ready) begin
                e = sb.pop_front(); acc++; n_checks++;
                if (key_out !== e.key || key_round !== e.rnd) begin
                    n_fail++;
                    $display("FAIL replay key got %h/%0d want %h/%0d", key_out, key_round, e.key, e.rnd);
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if (acc != 11 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL replay end got acc=%0d d=%b want 11 1", acc, done);
        end
        @(negedge clk);
        // start and replay together: start wins and restarts from the new key
        start = 1'b1; replay = 1'b1; key_in = fips[5];
        @(negedge clk);
        start = 1'b0; replay = 1'b0;
        n_checks++;
        if (key_out !== fips[5] || key_round !== 4'd10) begin
            n_fail++;
            $display("FAIL start_wins got %h/%0d want %h/10", key_out, key_round, fips[5]);
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
        @(negedge clk);
        replay = 1'b1;
        @(negedge clk);
        replay = 1'b0;
        n_checks++;
        if (key_valid !== 1'b1 || key_out !== fips[5] || key_round !== 4'd10) begin
            n_fail++;
            $display("FAIL replay_new got v=%b %h/%0d want 1 %h/10", key_valid, key_out, key_round, fips[5]);
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL replay_new timeout got d=%b want 1", done);
        end
        @(negedge clk);
`else
        replay = 1'b1; key_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || key_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL replay_ignored got b=%b v=%b want 0 0", busy, key_valid);
            end
        end
        replay = 1'b0;
`endif
    endtask

    task automatic test_abort();
        key_in = fips[10]; start = 1'b1; key_ready = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b0;
        n_rst = 1'b0;
        #1;
        n_checks++;
        if ({key_valid, busy, done, key_round} !== 7'd0 || key_out !== 128'd0) begin
            n_fail++;
            $display("FAIL abort got v=%b b=%b d=%b r=%0d k=%h want all 0", key_valid, busy, done, key_round, key_out);
        end
        @(negedge clk);
        n_rst = 1'b1; replay = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_after got d=%b b=%b want 0 0", done, busy);
            end
        end
        replay = 1'b0;
    endtask

    initial begin
        fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        rc_tab = '{8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

        test_reset();
        test_fips("fips", 0, 0);
        test_replay();
        test_fips("backpressure", 0, 5);
        test_fips("start_ignored", 5, 0);
        test_abort();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
